// File: rtl/bcd_serial_adder_ctrl.sv
// bcd_serial_adder_ctrl: digit-serial packed-BCD adder sequencer.
// One shared single-digit add-and-adjust stage is applied to the operands
// least-significant digit first, one digit per clock. The operands arrive and
// the result leaves over valid/ready handshakes.
// Optional feature macro: BCD_SUBTRACT_EN. When it is defined, the sub input
// selects nine's-complement subtraction. When it is undefined, the block only
// adds and sub is ignored.
module bcd_serial_adder_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  carry_out,
  output logic                  error,
  output logic                  overflow,
  output logic                  busy
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      a_q, b_q;        // operands, shifted right one digit per RUN cycle
  logic [W-1:0]      sum_q;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic              carry_out_q, error_q, overflow_q;

  logic              accept;
  logic              last_digit;
  logic              in_err;
  logic              cin_init;
  logic [3:0]        b_eff;
  logic [4:0]        s_raw;
  logic [3:0]        sum_dig;
  logic              c_next;
  logic              ov_next;

  // A digit above 9 in either operand is flagged at acceptance; the job still runs.
  logic [DIGITS-1:0] a_bad, b_bad;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_chk
    assign a_bad[gi] = (a[gi*4 +: 4] > 4'd9);
    assign b_bad[gi] = (b[gi*4 +: 4] > 4'd9);
  end
  assign in_err = (|a_bad) | (|b_bad);

`ifdef BCD_SUBTRACT_EN
  logic sub_q;
  // Subtraction adds the nine's complement of B with a carry-in of 1.
  assign cin_init = sub;
  assign b_eff    = sub_q ? 4'(4'd9 - b_q[3:0]) : b_q[3:0];
  // A subtraction without a final carry means the result is negative.
  assign ov_next  = sub_q ? ~c_next : c_next;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign cin_init   = 1'b0;
  assign b_eff      = b_q[3:0];
  assign ov_next    = c_next;
`endif

  assign accept     = in_valid && in_ready;
  assign last_digit = (idx_q == IDXW'(DIGITS - 1));

  // Shared single-digit BCD add with decimal adjust.
  always_comb begin
    s_raw   = {1'b0, a_q[3:0]} + {1'b0, b_eff} + {4'b0000, carry_q};
    sum_dig = s_raw[3:0];
    c_next  = 1'b0;
    if (s_raw > 5'd9) begin
      sum_dig = 4'(s_raw + 5'd6);
      c_next  = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_digit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. in_ready is held low for the whole time reset is asserted.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Datapath: latch on acceptance, then retire one digit per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      error_q     <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef BCD_SUBTRACT_EN
      sub_q       <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      idx_q   <= '0;
      carry_q <= cin_init;
      error_q <= in_err;
`ifdef BCD_SUBTRACT_EN
      sub_q   <= sub;
`endif
    end else if (state_q == RUN) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_q == IDXW'(i)) sum_q[i*4 +: 4] <= sum_dig;
      end
      a_q     <= a_q >> 4;
      b_q     <= b_q >> 4;
      carry_q <= c_next;
      idx_q   <= idx_q + 1'b1;
      if (last_digit) begin
        carry_out_q <= c_next;
        overflow_q  <= ov_next;
      end
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign error     = error_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Testbench for bcd_serial_adder_ctrl (DIGITS = 4). The reference model works
// on decimal integer values when all digits are legal. It falls back to the
// digit-by-digit rule when an operand holds a digit above 9.
// Subtraction cases are exercised when BCD_SUBTRACT_EN is defined.
module tb_bcd_serial_adder_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
`ifdef BCD_SUBTRACT_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out, error, overflow, busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0] obs_sum;
  logic         obs_carry, obs_ov, obs_err;

  bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .error(error),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    longint t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic void model(input logic [W-1:0] opa, input logic [W-1:0] opb, input bit s,
                                output logic [W-1:0] m_sum, output bit m_c,
                                output bit m_ov, output bit m_err);
    longint p = 1;
    longint r;
    int     cc;
    int     t;
    int     bd;
    m_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (opa[i*4 +: 4] > 9 || opb[i*4 +: 4] > 9) m_err = 1'b1;
      p = p * 10;
    end
    if (!m_err) begin
      if (!s) begin
        r     = bcd2int(opa) + bcd2int(opb);
        m_c   = (r >= p);
        m_sum = int2bcd(r % p);
      end else begin
        r     = bcd2int(opa) - bcd2int(opb);
        m_c   = (r >= 0);
        m_sum = int2bcd(m_c ? r : r + p);
      end
    end else begin
      cc    = s ? 1 : 0;
      m_sum = '0;
      for (int i = 0; i < DIGITS; i++) begin
        bd = int'(opb[i*4 +: 4]);
        if (s) bd = (9 - bd) & 15;
        t = int'(opa[i*4 +: 4]) + bd + cc;
        if (t > 9) begin
          m_sum[i*4 +: 4] = 4'((t + 6) & 15);
          cc = 1;
        end else begin
          m_sum[i*4 +: 4] = 4'(t);
          cc = 0;
        end
      end
      m_c = (cc != 0);
    end
    m_ov = s ? !m_c : m_c;
  endfunction

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && ($urandom_range(0, 7) == 0))
      r[$urandom_range(0, DIGITS - 1)*4 +: 4] = 4'($urandom_range(10, 15));
    return r;
  endfunction

  // Runs one job end to end. Outputs are sampled on falling edges.
  task automatic do_job(input logic [W-1:0] opa, input logic [W-1:0] opb, input bit s, input int hold);
    logic [W-1:0] m_sum;
    bit m_c, m_ov, m_err;
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    model(opa, opb, s & SUB_EN, m_sum, m_c, m_ov, m_err);
    a = opa; b = opb; sub = s; in_valid = 1'b1;
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    check("in_ready_in_run", in_ready, 0);
    // Scramble inputs while the job runs. The block must ignore them.
    lat = 0;
    while (!out_valid && lat < DIGITS + 5) begin
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, DIGITS);
    obs_sum = sum; obs_carry = carry_out; obs_ov = overflow; obs_err = error;
    check("sum", sum, m_sum);
    check("carry_out", carry_out, m_c);
    check("overflow", overflow, m_ov);
    check("error", error, m_err);
    check("in_ready_done", in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_sum", sum, m_sum);
      check("hold_carry", carry_out, m_c);
      check("hold_ovf", overflow, m_ov);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_after_ack", out_valid, 0);
    check("ready_after_ack", in_ready, 1);
    check("busy_after_ack", busy, 0);
    $display("[TB] job a=%h b=%h sub=%0d -> sum=%h c=%0d ovf=%0d err=%0d lat=%0d",
             opa, opb, s & SUB_EN, obs_sum, obs_carry, obs_ov, obs_err, lat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Directed cases.
    do_job(16'h1234, 16'h5678, 1'b0, 0);
    check("tp1_sum", obs_sum, 16'h6912);
    check("tp1_carry", obs_carry, 0);
    do_job(16'h9999, 16'h0001, 1'b0, 2);
    check("tp2_sum", obs_sum, 16'h0000);
    check("tp2_ovf", obs_ov, 1);
    do_job(16'h12A4, 16'h0000, 1'b0, 0);
    check("tp3_err", obs_err, 1);
    do_job(16'h4321, 16'h1111, 1'b0, 5);
    check("tp4_sum", obs_sum, 16'h5432);
`ifdef BCD_SUBTRACT_EN
    do_job(16'h5000, 16'h1234, 1'b1, 1);
    check("sub1_sum", obs_sum, 16'h3766);
    check("sub1_carry", obs_carry, 1);
    check("sub1_ovf", obs_ov, 0);
    do_job(16'h1234, 16'h5000, 1'b1, 1);
    check("sub2_sum", obs_sum, 16'h6234);
    check("sub2_carry", obs_carry, 0);
    check("sub2_ovf", obs_ov, 1);
`endif

    // Abort in the second RUN cycle.
    a = 16'h9A99; b = 16'h0999; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_sum", sum, 0);
    check("abort_error", error, 0);
    check("abort_carry", carry_out, 0);
    check("abort_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_release_ready", in_ready, 1);
    for (int k = 0; k < DIGITS + 2; k++) begin
      @(negedge clk);
      check("abort_no_valid", out_valid, 0);
    end
    do_job(16'h0005, 16'h0005, 1'b0, 0);
    check("after_abort_sum", obs_sum, 16'h0010);

    // Randomized jobs against the model.
    for (int j = 0; j < 40; j++) begin
      do_job(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder_ctrl.md
# bcd_serial_adder_ctrl

Digit-serial sequencer for multi-digit packed-BCD addition. It accepts two DIGITS-wide BCD operands over a valid/ready handshake and steps one shared single-digit BCD add-and-adjust stage across the digits, least-significant digit first, one digit per cycle. It then presents the sum, carry, error and overflow flags over a second valid/ready handshake. It replaces wide parallel BCD adder chains where area matters more than latency.

## Interface
- DIGITS, default 4: operand width in BCD digits; legal range 1..16.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
- b  input  4*DIGITS  operand B, same packing.
- sub  input  1  1 = A−B, 0 = A+B; ignored unless BCD_SUBTRACT_EN is defined.
- out_valid  output  1  result is valid; held until accepted.
- out_ready  input  1  downstream accepts the result.
- sum  output  4*DIGITS  packed BCD result.
- carry_out  output  1  carry out of the most-significant digit.
- error  output  1  some digit of a or b was greater than 9.
- overflow  output  1  result does not fit in DIGITS digits (add), or result is negative (sub).
- busy  output  1  high in RUN or DONE.

## Operation
- States:
  - IDLE → RUN on in_valid && in_ready. At that edge the block latches a, b and sub, sets digit index to 0 and sets the carry register to sub (0 for add).
  - RUN lasts exactly DIGITS cycles. In each cycle, digit i is combined as follows:
    - s = a_i + b'_i + c, computed 5 bits wide. b'_i = b_i for add, or (9 − b_i) mod 16 for sub.
    - If s > 9: sum_i = (s + 6)[3:0] and c = 1. Otherwise sum_i = s[3:0] and c = 0.
  - RUN → DONE after digit DIGITS−1 is written.
  - DONE → IDLE on out_valid && out_ready.
- error is the OR, over all digits of latched a and b, of (digit > 9). It is registered at acceptance.
  - Computation still completes using the rule above; no early abort.
- At RUN→DONE, carry_out = final c.
  - Add: overflow = carry_out.
  - Sub: overflow = ~carry_out, and sum holds the ten's complement of the magnitude.
- sum, carry_out, error and overflow are stable and valid whenever out_valid = 1. They are held until the next acceptance.
- In RUN and DONE, in_valid is ignored and inputs a, b and sub may change freely.
- There is no overlap between jobs: at least one IDLE cycle separates successive results.

## Timing
- Reset (asynchronous) sets:
  - state = IDLE;
  - in_ready = 0 while rst is high, and 1 in the first cycle after release;
  - out_valid, busy, sum, carry_out, error, overflow = 0.
- Latency: if operands are accepted at edge T, out_valid rises after edge T+DIGITS. The earliest possible result handshake is in the following cycle.
- Throughput: one result every DIGITS+2 cycles when out_ready is held high.
- in_ready and out_valid are never high together.
- out_valid with out_ready low: all outputs are held unchanged indefinitely.
- Reset asserted in RUN or DONE aborts the job. No out_valid is produced for the aborted operands.
- DIGITS = 1: RUN lasts one cycle.

## Configuration
- BCD_SUBTRACT_EN:
  - Defined: the sub port selects nine's-complement subtraction with carry-in 1, and overflow indicates a negative result.
  - Undefined: sub is ignored, the complement logic is not built, the carry-in is always 0, and overflow = carry_out.

## Test plan
- DIGITS=4, add 0x1234 + 0x5678 → after 4 RUN cycles: sum=0x6912, carry_out=0, overflow=0, error=0.
- Add 0x9999 + 0x0001 → sum=0x0000, carry_out=1, overflow=1.
- Add 0x12A4 + 0x0000 → error=1; out_valid still rises at the normal latency.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → sum, carry_out, overflow and out_valid are unchanged, and in_ready stays 0; with out_ready=1, the block returns to IDLE next cycle.
- BCD_SUBTRACT_EN defined:
  - 0x5000 − 0x1234 → sum=0x3766, carry_out=1, overflow=0.
  - 0x1234 − 0x5000 → sum=0x6234, carry_out=0, overflow=1.
- Assert rst in the 2nd RUN cycle → all outputs go to 0 immediately, and no out_valid appears; a new 0x0005 + 0x0005 job then gives sum=0x0010.
